// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder sequenced over WIDTH cycles, LSB first,
// with a registered carry and valid/ready handshakes on request and result.

// One-bit full adder: the whole arithmetic datapath of the controller below.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic c_o
);

  // Plain combinational sum and majority carry.
  always_comb begin
    sum_o = a_i ^ b_i ^ c_i;
    c_o   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int unsigned       CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0]   CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]   CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fa_sum, fa_carry;

  full_adder u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (carry_q),
    .sum_o(fa_sum),
    .c_o  (fa_carry)
  );

  // Next-state and datapath update; every register holds unless its state moves it.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        // Operands are captured only here, on the accept edge.
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Shift-and-insert form stays legal for WIDTH == 1 (no empty slice).
        sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        carry_d  = fa_carry;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CntOne;
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decoded from registers only; carry_q holds the final carry through DONE and IDLE.
  always_comb begin
    start_ready  = (state_q == StIdle);
    result_valid = (state_q == StDone);
    busy         = (state_q == StRun) || (state_q == StDone);
    sum          = sum_sh_q;
    c_out        = carry_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 scenarios plus exhaustive WIDTH=3 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       sv8, sr8, ci8, rv8, rr8, co8, bz8;
  logic [7:0] a8, b8, s8;
  // WIDTH=3 instance
  logic       sv3, sr3, ci3, rv3, rr3, co3, bz3;
  logic [2:0] a3, b3, s3;
  // WIDTH=1 instance
  logic       sv1, sr1, ci1, rv1, rr1, co1, bz1;
  logic [0:0] a1, b1, s1;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8), .a(a8), .b(b8),
    .c_in(ci8), .result_valid(rv8), .result_ready(rr8), .sum(s8), .c_out(co8), .busy(bz8)
  );
  serial_adder_ctrl #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv3), .start_ready(sr3), .a(a3), .b(b3),
    .c_in(ci3), .result_valid(rv3), .result_ready(rr3), .sum(s3), .c_out(co3), .busy(bz3)
  );
  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1), .a(a1), .b(b1),
    .c_in(ci1), .result_valid(rv1), .result_ready(rr1), .sum(s1), .c_out(co1), .busy(bz1)
  );

  // Present a request for one cycle; called 1 time unit after an edge while the DUT is idle.
  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    sv8 = 1'b1; a8 = a; b8 = b; ci8 = ci;
    @(posedge clk); #1;
    sv8 = 1'b0;
  endtask

  // Count edges from the accept edge until result_valid is seen (bounded).
  task automatic wait_valid8(output int lat);
    lat = 0;
    while (!rv8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sv8 = 0; a8 = 0; b8 = 0; ci8 = 0; rr8 = 0;
    sv3 = 0; a3 = 0; b3 = 0; ci3 = 0; rr3 = 0;
    sv1 = 0; a1 = 0; b1 = 0; ci1 = 0; rr1 = 0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({sr8, rv8, bz8, co8, s8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset8: {rdy,vld,busy,cout,sum}=%b want 1000_00000000", {sr8, rv8, bz8, co8, s8});
    end
    checks++;
    if ({sr3, rv3, bz3, sr1, rv1, bz1} !== 6'b100100) begin
      errors++;
      $display("FAIL reset3_1: got %b want 100100", {sr3, rv3, bz3, sr1, rv1, bz1});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    rr8 = 1'b1;
    accept8(8'h5A, 8'h3C, 1'b0);
    wait_valid8(lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
    checks++;
    if ({co8, s8} !== {1'b0, 8'h96}) begin
      errors++;
      $display("FAIL basic_sum: got c=%b s=%h want c=0 s=96", co8, s8);
    end
    @(posedge clk); #1;
    checks++;
    if ({rv8, sr8} !== 2'b01) begin
      errors++;
      $display("FAIL basic_pulse: {vld,rdy}=%b want 01", {rv8, sr8});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    rr8 = 1'b1;
    accept8(8'hFF, 8'h01, 1'b0);
    wait_valid8(lat);
    checks++;
    if ({co8, s8} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL b2b_first: got c=%b s=%h want c=1 s=00", co8, s8);
    end
    // Present the next request while DONE; it must be taken on the edge after the handshake.
    sv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rv8, sr8} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_handshake: {vld,rdy}=%b want 01", {rv8, sr8});
    end
    @(posedge clk); #1;
    sv8 = 1'b0;
    checks++;
    if ({bz8, sr8} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept: {busy,rdy}=%b want 10", {bz8, sr8});
    end
    wait_valid8(lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL b2b_latency: got %0d want 8", lat); end
    checks++;
    if ({co8, s8} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL b2b_second: got c=%b s=%h want c=1 s=ff", co8, s8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    rr8 = 1'b0;
    accept8(8'h12, 8'h34, 1'b0);
    wait_valid8(lat);
    for (int i = 0; i < 5; i++) begin
      sv8 = (i % 2 == 0); a8 = 8'hC3 + 8'(i); b8 = 8'h77; ci8 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({rv8, sr8, bz8, co8, s8} !== {3'b101, 1'b0, 8'h46}) begin
        errors++;
        $display("FAIL backpressure_hold%0d: {vld,rdy,busy,c,s}=%b want 101_0_01000110", i,
                 {rv8, sr8, bz8, co8, s8});
      end
    end
    sv8 = 1'b0;
    rr8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rv8, sr8, bz8, s8} !== {3'b010, 8'h46}) begin
      errors++;
      $display("FAIL backpressure_release: {vld,rdy,busy,s}=%b want 010_01000110",
               {rv8, sr8, bz8, s8});
    end
  endtask

  task automatic test_operand_stability;
    int lat;
    rr8 = 1'b1;
    accept8(8'hA7, 8'h6E, 1'b1);
    lat = 0;
    while (!rv8 && lat < 50) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = ~ci8;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({lat == 8, co8, s8} !== {1'b1, 1'b1, 8'h16}) begin
      errors++;
      $display("FAIL stability: lat=%0d c=%b s=%h want lat=8 c=1 s=16", lat, co8, s8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    int lat;
    logic seen;
    rr8 = 1'b1;
    accept8(8'h5A, 8'h3C, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sr8, rv8, bz8, co8, s8} !== {3'b100, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid: {rdy,vld,busy,c,s}=%b want 100_0_00000000", {sr8, rv8, bz8, co8, s8});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | rv8 | bz8;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_stale: activity=%b want 0", seen); end
    accept8(8'h80, 8'h80, 1'b0);
    wait_valid8(lat);
    checks++;
    if ({lat == 8, co8, s8} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL reset_recover: lat=%0d c=%b s=%h want lat=8 c=1 s=00", lat, co8, s8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive_w3;
    int lat;
    logic [3:0] exp_r;
    rr3 = 1'b1;
    for (int i = 0; i < 128; i++) begin
      sv3 = 1'b1; a3 = 3'(i >> 4); b3 = 3'(i >> 1); ci3 = 1'(i);
      exp_r = 4'(a3) + 4'(b3) + 4'(ci3);
      @(posedge clk); #1;
      sv3 = 1'b0;
      lat = 0;
      while (!rv3 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if ({lat == 3, co3, s3} !== {1'b1, exp_r}) begin
        errors++;
        $display("FAIL w3_case%0d: lat=%0d {c,s}=%b want lat=3 %b", i, lat, {co3, s3}, exp_r);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exhaustive_w1;
    int lat;
    logic [7:0] sum_tt;
    logic [7:0] car_tt;
    sum_tt = 8'b1001_0110;  // indexed by {a,b,c}
    car_tt = 8'b1110_1000;
    rr1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sv1 = 1'b1; a1 = 1'(i >> 2); b1 = 1'(i >> 1); ci1 = 1'(i);
      @(posedge clk); #1;
      sv1 = 1'b0;
      lat = 0;
      while (!rv1 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if ({lat == 1, co1, s1} !== {1'b1, car_tt[i], sum_tt[i]}) begin
        errors++;
        $display("FAIL w1_case%0d: lat=%0d {c,s}=%b want lat=1 %b", i, lat, {co1, s1},
                 {car_tt[i], sum_tt[i]});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_operand_stability();
    test_reset_mid_op();
    test_exhaustive_w3();
    test_exhaustive_w1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller. Accepts one WIDTH-bit addition request through a valid/ready handshake and sequences a single `full_adder` instance over WIDTH cycles, LSB first, with a registered carry. Returns the WIDTH-bit sum and carry-out through a second valid/ready handshake. It is the sequencing layer that turns the one-bit adder datapath into a multi-bit arithmetic resource at minimum area.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range 1..32.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous assert, active-low reset.
- `start_valid` input 1: request present; `a`, `b`, `c_in` valid while high.
- `start_ready` output 1: block can accept a request (high only in IDLE).
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `c_in` input 1: carry-in.
- `result_valid` output 1: `sum`/`c_out` hold a completed result.
- `result_ready` input 1: consumer accepts the result.
- `sum` output WIDTH: registered sum (a + b + c_in) mod 2^WIDTH.
- `c_out` output 1: registered carry-out of bit WIDTH-1.
- `busy` output 1: high in RUN or DONE.

## Operation
- Datapath: exactly one `full_adder` instance. Its inputs are `a_sh[0]`, `b_sh[0]` and the carry register; it produces one sum bit and the next carry.
- Internal state:
  - `a_sh`, `b_sh`: WIDTH-bit shift registers.
  - `carry`: 1-bit carry register.
  - `cnt`: bit counter, width $clog2(WIDTH+1).
  - `sum_sh`: WIDTH-bit result shift register, driving `sum`.
- States:
  - IDLE: `start_ready`=1. On `start_valid & start_ready` at an edge, load `a_sh`=a, `b_sh`=b, `carry`=c_in, `cnt`=0, and go to RUN. Otherwise stay.
  - RUN: each edge, `sum_sh` <= {fa_sum, sum_sh[WIDTH-1:1]}, `carry` <= fa_carry, `a_sh`/`b_sh` shift right by 1, `cnt`++. On the edge where `cnt`==WIDTH-1, go to DONE.
  - DONE: `result_valid`=1, `c_out`=`carry`. On `result_valid & result_ready` at an edge, go to IDLE. Otherwise hold every register.
- `a`, `b`, `c_in` are sampled only at the accept edge; changes at other times have no effect.
- `start_valid` outside IDLE is ignored; nothing is queued.
- `sum` and `c_out` keep their last result through IDLE until the next accept. During RUN, `sum` shows partial shift contents; it is valid only while `result_valid` is high.
- WIDTH=1: RUN lasts one cycle.
- Reset values (asynchronous, on `rst_n` low): state=IDLE, `start_ready`=1, `result_valid`=0, `busy`=0, `sum`=0, `c_out`=0, internal registers 0.
- Reset asserted during RUN or DONE aborts the operation. No `result_valid` pulse follows for that request.
- `start_ready`, `result_valid` and `busy` are decoded from registered state only, with no combinational input-to-output paths.

## Timing
- Accept at edge E0. RUN occupies edges E1..EWIDTH. `result_valid` rises after edge EWIDTH, i.e. latency = WIDTH cycles from the accept edge.
- Result consumed at edge Ek: `result_valid` is low and `start_ready` is high after Ek. The earliest next accept is edge Ek+1.
- Maximum throughput: one addition per WIDTH+2 cycles, with `result_ready` held high.
- Backpressure: DONE holds indefinitely with `sum`/`c_out` stable.
- Reset deassertion is synchronized externally. The first accept can occur on the first edge after `rst_n` rises.

## Test plan
- WIDTH=8; a=8'h5A, b=8'h3C, c_in=0, `result_ready`=1 -> `result_valid` exactly 8 cycles after the accept edge, `sum`=8'h96, `c_out`=0, one-cycle `result_valid` pulse.
- Two carry cases, back to back:
  - a=8'hFF, b=8'h01, c_in=0 -> `sum`=8'h00, `c_out`=1.
  - a=8'hFF, b=8'hFF, c_in=1 -> `sum`=8'hFF, `c_out`=1.
  - The second accept occurs exactly 1 cycle after the first result handshake.
- Backpressure: hold `result_ready`=0 for 5 cycles after `result_valid` rises, while pulsing `start_valid` with new operands -> `sum`/`c_out` stable, `start_ready`=0, no new operation starts. Then raise `result_ready` -> IDLE the next cycle.
- Operand stability: change `a`/`b` every cycle during RUN -> result equals the operands sampled at the accept edge.
- Reset mid-operation: assert `rst_n`=0 after 3 RUN cycles -> immediately state IDLE, `sum`=0, `c_out`=0, `result_valid`=0, `busy`=0. After release, no stale result appears and a new request completes correctly.
- Exhaustive check, WIDTH=3: loop all 128 {a, b, c_in} combinations -> {`c_out`, `sum`} == a+b+c_in for every request. Also run WIDTH=1, with all 8 combinations matching the `full_adder` truth table.
